rph_pulse_seq: RTL and testbench
================================

# rph_pulse_seq

Trigger-driven pulse-train sequencer for the RPH control logic. Once armed with a latched configuration, it waits for a trigger edge, then a programmable delay, then emits N pulses of programmable width and period on a single output. It reports busy, done and configuration errors to the PS-side register bank. It is the timing master that sequences the RPH drive datapath. Abort and reset are honoured in every state.

## Interface
- CNT_W, 32: width of delay, width and period counters and config fields
- NP_W, 16: width of pulse-count field and pulse_idx

- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- cfg_delay  in  CNT_W  cycles from trigger sample to first rising edge
- cfg_width  in  CNT_W  pulse high time in cycles
- cfg_period  in  CNT_W  rising-to-rising pulse spacing in cycles
- cfg_npulses  in  NP_W  number of pulses per train
- arm  in  1  single-cycle request: latch cfg_* and arm
- trig  in  1  trigger, synchronous to clk; rising edge detected internally
- abort  in  1  single-cycle request: stop immediately
- pulse_out  out  1  registered pulse output
- busy  out  1  high in ARMED, DELAY, HIGH and LOW
- done  out  1  one-cycle strobe on normal completion of a train
- aborted  out  1  one-cycle strobe when abort ends an active train
- err_cfg  out  1  one-cycle strobe when arm is rejected
- pulse_idx  out  NP_W  index of the current or last pulse, 0-based

## Operation
- States: IDLE, ARMED, DELAY, HIGH, LOW.
- All outputs reset to 0. State resets to IDLE. Latched config resets to 0. trig_q resets to 0.
- IDLE + arm:
  - If cfg_width==0, cfg_npulses==0 or cfg_period<=cfg_width (unsigned), the arm is rejected: err_cfg=1 for one cycle and the block stays in IDLE.
  - Otherwise cfg_* are latched, pulse_idx is cleared to 0, and the state becomes ARMED.
- arm outside IDLE is ignored. The latched config never changes while busy.
- Trigger edge is defined as trig=1 and trig_q=0, where trig_q is the registered trig. An edge is acted on only in ARMED; edges in any other state are dropped and not queued.
- ARMED + edge:
  - Delay 0 goes to HIGH.
  - Otherwise the block goes to DELAY with the counter loaded to cfg_delay-1.
- DELAY counts down to 0, then goes to HIGH.
- HIGH holds pulse_out=1 for cfg_width cycles, then goes to LOW.
- LOW holds pulse_out=0 for cfg_period-cfg_width cycles. On expiry, pulse_idx increments and the block returns to HIGH.
- Last pulse: at the end of HIGH when pulse_idx==cfg_npulses-1, the block goes to IDLE, done=1 for one cycle, and pulse_idx holds at N-1.
- abort:
  - In any busy state: next state IDLE, pulse_out=0, aborted=1 for one cycle, done=0.
  - In IDLE: no effect.
- Priority when events coincide: rst > abort > trigger/counter expiry > arm.
- Counters are CNT_W-bit unsigned and never wrap. Maximum-value fields (all ones) are legal and must be counted exactly.

## Timing
- Let k be the clock edge at which a trigger edge is sampled in ARMED, with latched values D, W, P, N.
- Pulse j (0..N-1): pulse_out rises at edge k+D+j·P and falls at edge k+D+j·P+W.
- done rises at edge k+D+(N-1)·P+W and is high for exactly one cycle. busy falls at that same edge.
- D=0 gives pulse_out high from edge k, i.e. first high cycle immediately after the sampling edge.
- abort sampled at edge a: pulse_out=0, busy=0 and aborted=1 from edge a.
- Async rst mid-train: pulse_out falls without waiting for a clock. No done or aborted is generated.
- New arm is accepted on the cycle after done, i.e. when the state is IDLE.

## Test plan
- Basic train: arm with D=3, W=2, P=5, N=3, trig edge sampled at edge 10 -> pulse_out high for edges 13-14, 18-19 and 23-24; done=1 only for the cycle starting at edge 25; pulse_idx sequence 0,1,2; busy 0 from edge 25.
- Zero delay, period of two: D=0, W=1, P=2, N=4, trig at edge 20 -> pulse_out 1,0,1,0,1,0,1,0 starting edge 20; done at edge 27.
- Rejected configs: arm with W=0; arm with N=0; arm with P=W=4 -> err_cfg one-cycle strobe each time, busy stays 0, later trig produces no pulse.
- Ignored inputs: trig edge while in IDLE -> no output; second arm while busy with different cfg -> train continues with the original values; trig held high across arm -> no pulse until trig falls and rises again.
- Abort mid-pulse: D=0, W=10, P=20, N=5, abort at edge k+3 -> pulse_out 0 and aborted=1 at k+3, done never asserted, then arm+trig succeed normally.
- Reset mid-train: assert rst asynchronously between edges during HIGH -> pulse_out, busy and pulse_idx go to 0 immediately; after release, the block is in IDLE and a trig edge produces no pulse.

Source files
------------

// File: rtl/rph_pulse_seq_if.sv
// Bus bundle between the PS-side register bank / trigger source and the RPH pulse sequencer.
// master drives configuration and requests; slave (the sequencer) drives status and the pulse.
interface rph_pulse_seq_if #(
  parameter int CNT_W = 32,
  parameter int NP_W  = 16
) ();

  logic [CNT_W-1:0] cfg_delay;
  logic [CNT_W-1:0] cfg_width;
  logic [CNT_W-1:0] cfg_period;
  logic [NP_W-1:0]  cfg_npulses;
  logic             arm;
  logic             trig;
  logic             abort;
  logic             pulse_out;
  logic             busy;
  logic             done;
  logic             aborted;
  logic             err_cfg;
  logic [NP_W-1:0]  pulse_idx;

  modport master (
    output cfg_delay,
    output cfg_width,
    output cfg_period,
    output cfg_npulses,
    output arm,
    output trig,
    output abort,
    input  pulse_out,
    input  busy,
    input  done,
    input  aborted,
    input  err_cfg,
    input  pulse_idx
  );

  modport slave (
    input  cfg_delay,
    input  cfg_width,
    input  cfg_period,
    input  cfg_npulses,
    input  arm,
    input  trig,
    input  abort,
    output pulse_out,
    output busy,
    output done,
    output aborted,
    output err_cfg,
    output pulse_idx
  );

endinterface

// File: rtl/rph_pulse_seq.sv
// Trigger-driven pulse-train sequencer: arm latches a config, a trigger edge starts
// delay -> N x (high W, low P-W) on pulse_out, with done/aborted/err_cfg strobes.
module rph_pulse_seq #(
  parameter int CNT_W = 32,
  parameter int NP_W  = 16
) (
  input  logic            clk,
  input  logic            rst,
  rph_pulse_seq_if.slave  seq_bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARMED = 3'd1;
  localparam logic [2:0] S_DELAY = 3'd2;
  localparam logic [2:0] S_HIGH  = 3'd3;
  localparam logic [2:0] S_LOW   = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] delay_q, delay_d;
  logic [CNT_W-1:0] width_q, width_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [NP_W-1:0]  npulses_q, npulses_d;
  logic [NP_W-1:0]  idx_q, idx_d;
  logic             trig_q;
  logic             pulse_q, pulse_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;
  logic             err_q, err_d;

  logic             trigEdge;
  logic             cfgBad;
  logic             cntZero;
  logic             lastPulse;
  logic             isBusy;

  assign trigEdge  = seq_bus.trig && !trig_q;
  assign cfgBad    = (seq_bus.cfg_width == '0) || (seq_bus.cfg_npulses == '0) ||
                     (seq_bus.cfg_period <= seq_bus.cfg_width);
  assign cntZero   = (cnt_q == '0);
  assign lastPulse = (idx_q == (npulses_q - NP_W'(1)));
  assign isBusy    = (state_q != S_IDLE);

  // Counters are loaded with length-1 so that expiry lands exactly on the boundary edge.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    delay_d   = delay_q;
    width_d   = width_q;
    period_d  = period_q;
    npulses_d = npulses_q;
    idx_d     = idx_q;
    pulse_d   = pulse_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    err_d     = 1'b0;

    if (seq_bus.abort && isBusy) begin
      state_d   = S_IDLE;
      pulse_d   = 1'b0;
      aborted_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (seq_bus.arm) begin
            if (cfgBad) begin
              err_d = 1'b1;
            end else begin
              delay_d   = seq_bus.cfg_delay;
              width_d   = seq_bus.cfg_width;
              period_d  = seq_bus.cfg_period;
              npulses_d = seq_bus.cfg_npulses;
              idx_d     = '0;
              state_d   = S_ARMED;
            end
          end
        end

        S_ARMED: begin
          if (trigEdge) begin
            if (delay_q == '0) begin
              state_d = S_HIGH;
              pulse_d = 1'b1;
              cnt_d   = width_q - CNT_W'(1);
            end else begin
              state_d = S_DELAY;
              cnt_d   = delay_q - CNT_W'(1);
            end
          end
        end

        S_DELAY: begin
          if (cntZero) begin
            state_d = S_HIGH;
            pulse_d = 1'b1;
            cnt_d   = width_q - CNT_W'(1);
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end

        S_HIGH: begin
          if (cntZero) begin
            pulse_d = 1'b0;
            if (lastPulse) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = S_LOW;
              cnt_d   = period_q - width_q - CNT_W'(1);
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end

        S_LOW: begin
          if (cntZero) begin
            state_d = S_HIGH;
            pulse_d = 1'b1;
            idx_d   = idx_q + NP_W'(1);
            cnt_d   = width_q - CNT_W'(1);
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end

        default: begin
          state_d = S_IDLE;
          pulse_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      delay_q   <= '0;
      width_q   <= '0;
      period_q  <= '0;
      npulses_q <= '0;
      idx_q     <= '0;
      trig_q    <= 1'b0;
      pulse_q   <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      delay_q   <= delay_d;
      width_q   <= width_d;
      period_q  <= period_d;
      npulses_q <= npulses_d;
      idx_q     <= idx_d;
      trig_q    <= seq_bus.trig;
      pulse_q   <= pulse_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      err_q     <= err_d;
    end
  end

  assign seq_bus.pulse_out = pulse_q;
  assign seq_bus.busy      = isBusy;
  assign seq_bus.done      = done_q;
  assign seq_bus.aborted   = aborted_q;
  assign seq_bus.err_cfg   = err_q;
  assign seq_bus.pulse_idx = idx_q;

`ifndef SYNTHESIS
  // The output pulse is only ever high while the FSM sits in HIGH.
  a_pulse_in_high: assert property (@(posedge clk) disable iff (rst)
    pulse_q |-> (state_q == S_HIGH));
  a_done_xor_abort: assert property (@(posedge clk) disable iff (rst)
    !(done_q && aborted_q));
  a_cfg_legal: assert property (@(posedge clk) disable iff (rst)
    isBusy |-> ((width_q != '0) && (npulses_q != '0) && (period_q > width_q)));
`endif

endmodule

// File: tb/tb_rph_pulse_seq.sv
// Self-checking bench for rph_pulse_seq: directed scenarios plus randomized trains
// compared cycle by cycle against the edge formulas of the pulse-train timing.
module tb_rph_pulse_seq;

  localparam int CNT_W = 32;
  localparam int NP_W  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   edgeCnt = 0;
  int   checks  = 0;
  int   passes  = 0;

  rph_pulse_seq_if #(.CNT_W(CNT_W), .NP_W(NP_W)) bus ();

  rph_pulse_seq #(.CNT_W(CNT_W), .NP_W(NP_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .seq_bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edgeCnt <= edgeCnt + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  // Pulse j is high for edges k+D+j*P .. k+D+j*P+W-1.
  function automatic bit modelPulse(int t, int k, int d, int w, int p, int n);
    for (int j = 0; j < n; j++)
      if (t >= k + d + j * p && t < k + d + j * p + w) return 1'b1;
    return 1'b0;
  endfunction

  // Index becomes j when pulse j rises, and holds at N-1 afterwards.
  function automatic int modelIdx(int t, int k, int d, int p, int n);
    int idx = 0;
    for (int j = 1; j < n; j++)
      if (t >= k + d + j * p) idx = j;
    return idx;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int d, input int w, input int p, input int n, input bit doArm);
    bus.cfg_delay   = CNT_W'(d);
    bus.cfg_width   = CNT_W'(w);
    bus.cfg_period  = CNT_W'(p);
    bus.cfg_npulses = NP_W'(n);
    bus.arm         = doArm;
  endtask

  // mode: 0 plain, 1 re-arm mid-train, 2 trig held high across arm, 3 trig noise during train
  task automatic test_train(input string name, input int d, input int w, input int p, input int n,
                            input int lead, input int mode, output int doneObs, output int highObs);
    int k;
    int doneEdge;
    bit expP;
    bit expB;
    bit expD;
    int expI;
    doneObs = -1;
    highObs = 0;
    if (mode == 2) begin
      bus.trig = 1'b1;
      tick();
    end
    applyStimulus(d, w, p, n, 1'b1);
    tick();
    bus.arm = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) $display("[TB] FAIL %s arm_busy: got %b want 1", name, bus.busy);
    else passes++;
    checks++;
    if ({bus.done, bus.err_cfg} !== 2'b00)
      $display("[TB] FAIL %s arm_strobes: got %b want 00", name, {bus.done, bus.err_cfg});
    else passes++;
    checks++;
    if (bus.pulse_idx !== '0) $display("[TB] FAIL %s arm_idx: got %0d want 0", name, bus.pulse_idx);
    else passes++;
    for (int i = 0; i < lead; i++) begin
      tick();
      checks++;
      if ({bus.busy, bus.pulse_out} !== 2'b10)
        $display("[TB] FAIL %s armed_wait: got %b want 10", name, {bus.busy, bus.pulse_out});
      else passes++;
    end
    if (mode == 2) begin
      bus.trig = 1'b0;
      tick();
      checks++;
      if ({bus.busy, bus.pulse_out} !== 2'b10)
        $display("[TB] FAIL %s held_trig: got %b want 10", name, {bus.busy, bus.pulse_out});
      else passes++;
    end
    bus.trig = 1'b1;
    tick();
    k = edgeCnt;
    bus.trig = 1'b0;
    doneEdge = k + d + (n - 1) * p + w;
    for (int t = k; t <= doneEdge; t++) begin
      if (t != k) tick();
      expP = modelPulse(edgeCnt, k, d, w, p, n);
      expB = (edgeCnt < doneEdge);
      expD = (edgeCnt == doneEdge);
      expI = modelIdx(edgeCnt, k, d, p, n);
      checks++;
      if (bus.pulse_out !== expP)
        $display("[TB] FAIL %s pulse_out @k+%0d: got %b want %b", name, edgeCnt - k, bus.pulse_out, expP);
      else passes++;
      checks++;
      if (bus.busy !== expB)
        $display("[TB] FAIL %s busy @k+%0d: got %b want %b", name, edgeCnt - k, bus.busy, expB);
      else passes++;
      checks++;
      if (bus.done !== expD)
        $display("[TB] FAIL %s done @k+%0d: got %b want %b", name, edgeCnt - k, bus.done, expD);
      else passes++;
      checks++;
      if (bus.pulse_idx !== NP_W'(expI))
        $display("[TB] FAIL %s pulse_idx @k+%0d: got %0d want %0d", name, edgeCnt - k, bus.pulse_idx, expI);
      else passes++;
      checks++;
      if ({bus.aborted, bus.err_cfg} !== 2'b00)
        $display("[TB] FAIL %s stray_strobe @k+%0d: got %b want 00", name, edgeCnt - k, {bus.aborted, bus.err_cfg});
      else passes++;
      if (bus.done === 1'b1 && doneObs < 0) doneObs = edgeCnt - k;
      if (bus.pulse_out === 1'b1) highObs++;
      if (mode == 1 && edgeCnt == k + 1) applyStimulus(d + 3, w + 1, p + 2, n + 1, 1'b1);
      else bus.arm = 1'b0;
      if (mode == 3) bus.trig = (edgeCnt < doneEdge - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bus.arm   = 1'b0;
    bus.trig  = 1'b0;
    bus.abort = 1'b0;
    applyStimulus(0, 0, 0, 0, 1'b0);
    repeat (3) tick();
    checks++;
    if ({bus.pulse_out, bus.busy, bus.done, bus.aborted, bus.err_cfg} !== 5'b0)
      $display("[TB] FAIL reset_flags: got %b want 00000",
               {bus.pulse_out, bus.busy, bus.done, bus.aborted, bus.err_cfg});
    else passes++;
    checks++;
    if (bus.pulse_idx !== '0) $display("[TB] FAIL reset_idx: got %0d want 0", bus.pulse_idx);
    else passes++;
    #2 rst = 1'b0;
    tick();
    checks++;
    if ({bus.pulse_out, bus.busy} !== 2'b00)
      $display("[TB] FAIL reset_release_idle: got %b want 00", {bus.pulse_out, bus.busy});
    else passes++;
  endtask

  task automatic test_basic_train();
    int doneObs;
    int highObs;
    test_train("basic", 3, 2, 5, 3, 1, 0, doneObs, highObs);
    checks++;
    if (doneObs !== 15) $display("[TB] FAIL basic_done_edge: got k+%0d want k+15", doneObs);
    else passes++;
    checks++;
    if (highObs !== 6) $display("[TB] FAIL basic_high_cycles: got %0d want 6", highObs);
    else passes++;
  endtask

  task automatic test_zero_delay();
    int doneObs;
    int highObs;
    test_train("zero_delay", 0, 1, 2, 4, 0, 0, doneObs, highObs);
    checks++;
    if (doneObs !== 7) $display("[TB] FAIL zero_delay_done_edge: got k+%0d want k+7", doneObs);
    else passes++;
    checks++;
    if (highObs !== 4) $display("[TB] FAIL zero_delay_high_cycles: got %0d want 4", highObs);
    else passes++;
  endtask

  task automatic test_back_to_back();
    int doneObs;
    int highObs;
    test_train("b2b_first", 1, 2, 3, 2, 0, 0, doneObs, highObs);
    test_train("b2b_second", 0, 3, 4, 2, 2, 0, doneObs, highObs);
    checks++;
    if (doneObs !== 7) $display("[TB] FAIL b2b_done_edge: got k+%0d want k+7", doneObs);
    else passes++;
  endtask

  task automatic test_rejected_cfg();
    bit activity;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       applyStimulus(2, 0, 5, 3, 1'b1);
        1:       applyStimulus(2, 3, 8, 0, 1'b1);
        default: applyStimulus(2, 4, 4, 3, 1'b1);
      endcase
      tick();
      bus.arm = 1'b0;
      checks++;
      if ({bus.err_cfg, bus.busy} !== 2'b10)
        $display("[TB] FAIL reject%0d_strobe: got err/busy %b want 10", i, {bus.err_cfg, bus.busy});
      else passes++;
      tick();
      checks++;
      if (bus.err_cfg !== 1'b0) $display("[TB] FAIL reject%0d_one_cycle: got %b want 0", i, bus.err_cfg);
      else passes++;
      bus.trig = 1'b1;
      tick();
      bus.trig = 1'b0;
      activity = 1'b0;
      repeat (8) begin
        tick();
        activity |= bus.pulse_out | bus.busy | bus.done;
      end
      checks++;
      if (activity !== 1'b0) $display("[TB] FAIL reject%0d_no_pulse: got activity %b want 0", i, activity);
      else passes++;
    end
  endtask

  task automatic test_ignored_inputs();
    bit activity;
    int doneObs;
    int highObs;
    bus.trig = 1'b1;
    tick();
    bus.trig = 1'b0;
    activity = 1'b0;
    repeat (6) begin
      tick();
      activity |= bus.pulse_out | bus.busy | bus.done;
    end
    checks++;
    if (activity !== 1'b0) $display("[TB] FAIL idle_trig: got activity %b want 0", activity);
    else passes++;
    test_train("rearm_busy", 2, 3, 6, 3, 1, 1, doneObs, highObs);
    checks++;
    if (doneObs !== 17) $display("[TB] FAIL rearm_done_edge: got k+%0d want k+17", doneObs);
    else passes++;
    test_train("trig_held", 1, 2, 4, 2, 2, 2, doneObs, highObs);
    checks++;
    if (highObs !== 4) $display("[TB] FAIL trig_held_high_cycles: got %0d want 4", highObs);
    else passes++;
  endtask

  task automatic test_abort();
    bit activity;
    int doneObs;
    int highObs;
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    checks++;
    if ({bus.aborted, bus.busy} !== 2'b00)
      $display("[TB] FAIL abort_idle: got aborted/busy %b want 00", {bus.aborted, bus.busy});
    else passes++;
    applyStimulus(0, 10, 20, 5, 1'b1);
    tick();
    bus.arm  = 1'b0;
    bus.trig = 1'b1;
    tick();
    bus.trig = 1'b0;
    checks++;
    if (bus.pulse_out !== 1'b1) $display("[TB] FAIL abort_pre_high: got %b want 1", bus.pulse_out);
    else passes++;
    repeat (2) tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    checks++;
    if ({bus.pulse_out, bus.busy, bus.aborted, bus.done} !== 4'b0010)
      $display("[TB] FAIL abort_mid_pulse: got pulse/busy/aborted/done %b want 0010",
               {bus.pulse_out, bus.busy, bus.aborted, bus.done});
    else passes++;
    tick();
    checks++;
    if (bus.aborted !== 1'b0) $display("[TB] FAIL abort_one_cycle: got %b want 0", bus.aborted);
    else passes++;
    activity = 1'b0;
    repeat (30) begin
      tick();
      activity |= bus.pulse_out | bus.done | bus.busy;
    end
    checks++;
    if (activity !== 1'b0) $display("[TB] FAIL abort_quiet_after: got activity %b want 0", activity);
    else passes++;
    applyStimulus(1, 1, 3, 2, 1'b1);
    tick();
    bus.arm = 1'b0;
    tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    checks++;
    if ({bus.aborted, bus.busy} !== 2'b10)
      $display("[TB] FAIL abort_armed: got aborted/busy %b want 10", {bus.aborted, bus.busy});
    else passes++;
    bus.trig = 1'b1;
    tick();
    bus.trig = 1'b0;
    activity = 1'b0;
    repeat (6) begin
      tick();
      activity |= bus.pulse_out | bus.busy;
    end
    checks++;
    if (activity !== 1'b0) $display("[TB] FAIL abort_armed_trig: got activity %b want 0", activity);
    else passes++;
    test_train("post_abort", 2, 2, 3, 2, 1, 0, doneObs, highObs);
  endtask

  task automatic test_reset_mid_train();
    bit activity;
    applyStimulus(0, 2, 4, 4, 1'b1);
    tick();
    bus.arm  = 1'b0;
    bus.trig = 1'b1;
    tick();
    bus.trig = 1'b0;
    repeat (4) tick();
    checks++;
    if ({bus.pulse_out, bus.pulse_idx} !== {1'b1, NP_W'(1)})
      $display("[TB] FAIL rst_pre_state: got pulse %b idx %0d want pulse 1 idx 1", bus.pulse_out, bus.pulse_idx);
    else passes++;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.pulse_out, bus.busy, bus.done, bus.aborted} !== 4'b0000)
      $display("[TB] FAIL rst_async_flags: got %b want 0000",
               {bus.pulse_out, bus.busy, bus.done, bus.aborted});
    else passes++;
    checks++;
    if (bus.pulse_idx !== '0) $display("[TB] FAIL rst_async_idx: got %0d want 0", bus.pulse_idx);
    else passes++;
    repeat (2) tick();
    #2 rst = 1'b0;
    tick();
    checks++;
    if ({bus.busy, bus.done, bus.aborted} !== 3'b000)
      $display("[TB] FAIL rst_release: got %b want 000", {bus.busy, bus.done, bus.aborted});
    else passes++;
    bus.trig = 1'b1;
    tick();
    bus.trig = 1'b0;
    activity = 1'b0;
    repeat (10) begin
      tick();
      activity |= bus.pulse_out | bus.busy | bus.done | bus.aborted;
    end
    checks++;
    if (activity !== 1'b0) $display("[TB] FAIL rst_trig_ignored: got activity %b want 0", activity);
    else passes++;
  endtask

  task automatic test_random_trains();
    int d;
    int w;
    int p;
    int n;
    int lead;
    int doneObs;
    int highObs;
    for (int i = 0; i < 25; i++) begin
      d    = int'($urandom_range(0, 6));
      w    = int'($urandom_range(1, 4));
      p    = w + int'($urandom_range(1, 5));
      n    = int'($urandom_range(1, 4));
      lead = int'($urandom_range(0, 3));
      test_train($sformatf("rand%0d", i), d, w, p, n, lead, (i % 2 == 0) ? 3 : 0, doneObs, highObs);
    end
  endtask

  initial begin
    $display("[TB] starting rph_pulse_seq bench");
    test_reset();
    test_basic_train();
    test_zero_delay();
    test_back_to_back();
    test_rejected_cfg();
    test_ignored_inputs();
    test_abort();
    test_reset_mid_train();
    test_random_trains();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
